uart_cmd_ctrl: RTL and testbench

//  Command sequencer between the UART receiver and the SDRAM controller.
//  - Parses the received byte stream into write and read commands.
//  - Streams write payload bytes into the SDRAM write FIFO.
//  - Raises and holds write/read triggers until the SDRAM controller acknowledges them.
//  - Aborts stalled frames with an inter-byte timeout and flags protocol errors.

---
 rtl/uart_sdram_pkg.sv | 19 +
 rtl/cmd_timeout_cnt.sv | 32 +++
 rtl/uart_cmd_ctrl.sv | 117 +++++++++++
 tb/tb_uart_cmd_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_sdram_pkg.sv
// Shared constants and types for the UART-to-SDRAM command path.
// Header bytes, FSM state encoding and timeout limits.
package uart_sdram_pkg;

  localparam logic [7:0] WR_CMD = 8'h55;
  localparam logic [7:0] RD_CMD = 8'hAA;

  localparam int TIMEOUT_SYN = 52080;
  localparam int TIMEOUT_SIM = 280;
  localparam int TO_W        = 17;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_DATA = 2'd1,
    WR_TRIG = 2'd2,
    RD_TRIG = 2'd3
  } state_t;

endpackage

// File: rtl/cmd_timeout_cnt.sv
// Inter-byte idle counter with clear, enable and saturation.
// tc flags an enabled cycle spent at the terminal count.
import uart_sdram_pkg::*;

module cmd_timeout_cnt #(
  parameter int W    = TO_W,
  parameter int TERM = TIMEOUT_SIM
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [W-1:0] MAX = W'(TERM - 1);

  logic [W-1:0] cnt;

  // count idle cycles, holding at the terminal value
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (en && cnt != MAX)
      cnt <= cnt + 1'b1;
  end

  assign tc = en && (cnt == MAX);

endmodule

// File: rtl/uart_cmd_ctrl.sv
// UART command sequencer: parses write/read frames, feeds the
// SDRAM write FIFO and holds triggers until acknowledged.
import uart_sdram_pkg::*;

module uart_cmd_ctrl #(
  parameter int BURST_LEN = 4,
  parameter int TIMEOUT   = TIMEOUT_SYN
) (
  input  logic       sclk,
  input  logic       s_rst,
  input  logic [7:0] rx_data,
  input  logic       po_flag,
  input  logic       wr_ack,
  input  logic       rd_ack,
  output logic       wfifo_wr_en,
  output logic [7:0] wfifo_data,
  output logic       wfifo_clr,
  output logic       wr_trig,
  output logic       rd_trig,
  output logic       cmd_err
);

  localparam logic [7:0] LAST = 8'(BURST_LEN - 1);

  state_t     state, state_nxt;
  logic [7:0] byte_cnt, byte_cnt_nxt;
  logic       wr_en_nxt, clr_nxt, err_nxt;
  logic       to_clr, to_en, to_tc;

  cmd_timeout_cnt #(
    .W    (TO_W),
    .TERM (TIMEOUT)
  ) u_to (
    .clk (sclk),
    .rst (s_rst),
    .clr (to_clr),
    .en  (to_en),
    .tc  (to_tc)
  );

  // next-state and next-output decode
  always_comb begin
    state_nxt    = state;
    byte_cnt_nxt = byte_cnt;
    wr_en_nxt    = 1'b0;
    clr_nxt      = 1'b0;
    err_nxt      = 1'b0;
    to_clr       = 1'b1;
    to_en        = 1'b0;
    unique case (state)
      IDLE: begin
        if (po_flag) begin
          if (rx_data == WR_CMD) begin
            state_nxt    = WR_DATA;
            byte_cnt_nxt = '0;
          end else if (rx_data == RD_CMD) begin
            state_nxt = RD_TRIG;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      WR_DATA: begin
        if (po_flag) begin
          wr_en_nxt    = 1'b1;
          byte_cnt_nxt = byte_cnt + 1'b1;
          if (byte_cnt == LAST)
            state_nxt = WR_TRIG;
        end else begin
          to_clr = 1'b0;
          to_en  = 1'b1;
          if (to_tc) begin
            err_nxt   = 1'b1;
            clr_nxt   = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      WR_TRIG: begin
        err_nxt = po_flag;
        if (wr_ack)
          state_nxt = IDLE;
      end
      RD_TRIG: begin
        err_nxt = po_flag;
        if (rd_ack)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // state and registered outputs
  always_ff @(posedge sclk or posedge s_rst) begin
    if (s_rst) begin
      state       <= IDLE;
      byte_cnt    <= '0;
      wfifo_wr_en <= 1'b0;
      wfifo_data  <= '0;
      wfifo_clr   <= 1'b0;
      wr_trig     <= 1'b0;
      rd_trig     <= 1'b0;
      cmd_err     <= 1'b0;
    end else begin
      state       <= state_nxt;
      byte_cnt    <= byte_cnt_nxt;
      wfifo_wr_en <= wr_en_nxt;
      if (wr_en_nxt)
        wfifo_data <= rx_data;
      wfifo_clr   <= clr_nxt;
      cmd_err     <= err_nxt;
      wr_trig     <= (state_nxt == WR_TRIG);
      rd_trig     <= (state_nxt == RD_TRIG);
    end
  end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Bench for uart_cmd_ctrl: directed frames plus random traffic,
// every cycle compared against a frame-level reference model.
module tb_uart_cmd_ctrl;

  localparam int BL = 4;
  localparam int TO = 280;

  localparam int M_IDLE = 0;
  localparam int M_PAY  = 1;
  localparam int M_WRW  = 2;
  localparam int M_RDW  = 3;

  logic       sclk = 1'b0;
  logic       s_rst;
  logic [7:0] rx_data;
  logic       po_flag, wr_ack, rd_ack;
  logic       wfifo_wr_en, wfifo_clr;
  logic [7:0] wfifo_data;
  logic       wr_trig, rd_trig, cmd_err;

  uart_cmd_ctrl #(
    .BURST_LEN (BL),
    .TIMEOUT   (TO)
  ) dut (
    .sclk        (sclk),
    .s_rst       (s_rst),
    .rx_data     (rx_data),
    .po_flag     (po_flag),
    .wr_ack      (wr_ack),
    .rd_ack      (rd_ack),
    .wfifo_wr_en (wfifo_wr_en),
    .wfifo_data  (wfifo_data),
    .wfifo_clr   (wfifo_clr),
    .wr_trig     (wr_trig),
    .rd_trig     (rd_trig),
    .cmd_err     (cmd_err)
  );

  always #5 sclk = ~sclk;

  int n_chk  = 0;
  int n_pass = 0;

  int         m_mode = M_IDLE;
  int         m_got  = 0;
  int         m_idle = 0;
  logic       e_en, e_clr, e_err;
  logic [7:0] e_data;

  task automatic chk(input string tag, input logic [7:0] got,
                     input logic [7:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, got, exp);
  endtask

  task automatic model(input logic po, input logic [7:0] d,
                       input logic wa, input logic ra);
    e_en  = 1'b0;
    e_clr = 1'b0;
    e_err = 1'b0;
    case (m_mode)
      M_IDLE:
        if (po) begin
          if (d == 8'h55) begin
            m_mode = M_PAY;
            m_got  = 0;
            m_idle = 0;
          end else if (d == 8'hAA) m_mode = M_RDW;
          else e_err = 1'b1;
        end
      M_PAY:
        if (po) begin
          e_en   = 1'b1;
          e_data = d;
          m_got  = m_got + 1;
          m_idle = 0;
          if (m_got == BL) m_mode = M_WRW;
        end else if (m_idle == TO - 1) begin
          e_err  = 1'b1;
          e_clr  = 1'b1;
          m_mode = M_IDLE;
        end else m_idle = m_idle + 1;
      M_WRW: begin
        e_err = po;
        if (wa) m_mode = M_IDLE;
      end
      default: begin
        e_err = po;
        if (ra) m_mode = M_IDLE;
      end
    endcase
  endtask

  task automatic cycle(input logic po, input logic [7:0] d,
                       input logic wa, input logic ra);
    @(negedge sclk);
    po_flag = po;
    rx_data = d;
    wr_ack  = wa;
    rd_ack  = ra;
    @(posedge sclk);
    model(po, d, wa, ra);
    #1;
    chk("wr_en", 8'(wfifo_wr_en), 8'(e_en));
    if (e_en) chk("data", wfifo_data, e_data);
    chk("clr", 8'(wfifo_clr), 8'(e_clr));
    chk("err", 8'(cmd_err), 8'(e_err));
    chk("wr_trig", 8'(wr_trig), 8'(m_mode == M_WRW));
    chk("rd_trig", 8'(rd_trig), 8'(m_mode == M_RDW));
  endtask

  task automatic send(input logic [7:0] b);
    cycle(1'b1, b, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic frame(input logic [7:0] b0);
    send(8'h55);
    for (int i = 0; i < BL; i++) send(b0 + 8'(i * 17));
  endtask

  task automatic do_reset();
    @(negedge sclk);
    #2;
    s_rst   = 1'b1;
    po_flag = 1'b0;
    wr_ack  = 1'b0;
    rd_ack  = 1'b0;
    #1;
    chk("rst_wr_en", 8'(wfifo_wr_en), 8'h00);
    chk("rst_data", wfifo_data, 8'h00);
    chk("rst_clr", 8'(wfifo_clr), 8'h00);
    chk("rst_wr_trig", 8'(wr_trig), 8'h00);
    chk("rst_rd_trig", 8'(rd_trig), 8'h00);
    chk("rst_err", 8'(cmd_err), 8'h00);
    m_mode = M_IDLE;
    m_got  = 0;
    m_idle = 0;
    @(negedge sclk);
    s_rst = 1'b0;
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] b;
    int r;
    s_rst   = 1'b1;
    rx_data = 8'h00;
    po_flag = 1'b0;
    wr_ack  = 1'b0;
    rd_ack  = 1'b0;
    do_reset();
    idle(2);

    // write frame and ack
    send(8'h55); send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    idle(3);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    idle(2);

    // read held without ack
    send(8'hAA);
    idle(100);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    idle(2);

    // stray acks while no trigger is pending
    cycle(1'b0, 8'h00, 1'b1, 1'b1);

    // unknown header then a good frame
    send(8'h3C);
    frame(8'h5A);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // timeout mid-frame
    send(8'h55); send(8'h11);
    idle(TO + 3);

    // longest gap that is still accepted
    send(8'h55); send(8'h11);
    idle(TO - 1);
    send(8'h22); send(8'h33); send(8'h44);
    idle(1);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // header bytes inside the payload
    send(8'h55); send(8'hAA); send(8'h55); send(8'h3C); send(8'hAA);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // byte collides with ack
    frame(8'h01);
    idle(1);
    cycle(1'b1, 8'h77, 1'b1, 1'b0);
    idle(2);
    send(8'hAA);
    cycle(1'b1, 8'h55, 1'b0, 1'b1);
    idle(2);

    // reset mid-frame
    send(8'h55); send(8'h11);
    do_reset();
    frame(8'h90);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    idle(2);

    // random traffic
    for (int k = 0; k < 600; k++) begin
      r = $urandom_range(0, 99);
      if (r < 3) idle($urandom_range(TO - 3, TO + 3));
      else begin
        r = $urandom_range(0, 99);
        if (r < 30) b = 8'h55;
        else if (r < 45) b = 8'hAA;
        else b = 8'($urandom);
        cycle($urandom_range(0, 2) != 0, b,
              $urandom_range(0, 7) == 0,
              $urandom_range(0, 7) == 0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
